wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Writeback-side consumer of the M/WB pipeline register outputs.
- Selects the writeback value (memory load or ALU/link result) and commits it to the 32-entry general-purpose register file.
- Serves the two combinational ID-stage read ports with write-through bypass.
- Exports the selected writeback value for EX-stage forwarding.

Parameters:
- data_size, 32, register/data width in bits
- addr_size, 5, register index width
- reg_count, 32, number of architectural registers (2**addr_size)

Ports:
- clk  input  1  system clock; register array writes on posedge (pipeline registers update on negedge)
- rst  input  1  reset, asynchronous, active-high
- WB_MemtoReg  input  1  1 = write back memory data, 0 = write back ALU/link data
- WB_RegWrite  input  1  writeback enable
- WB_DM_Read_Data  input  data_size  load data from M/WB
- WB_WD_out  input  data_size  ALU/link result from M/WB
- WB_WR_out  input  addr_size  destination register index
- Read_addr_1  input  addr_size  rs index from ID
- Read_addr_2  input  addr_size  rt index from ID
- Read_data_1  output  data_size  rs value
- Read_data_2  output  data_size  rt value
- WB_Write_Data  output  data_size  selected writeback value (to forwarding mux)
- WB_Write_Valid  output  1  WB_RegWrite and WB_WR_out != 0 (forwarding qualifier)

Behaviour:
- Write data select (combinational): WB_Write_Data = WB_MemtoReg ? WB_DM_Read_Data : WB_WD_out. This path is not gated by WB_RegWrite.
- WB_Write_Valid = WB_RegWrite && (WB_WR_out != 0); forced 0 while rst = 1.
- Commit:
  - On posedge clk with rst = 0 and WB_Write_Valid = 1: regs[WB_WR_out] <= WB_Write_Data.
  - Writes to index 0 are discarded. regs[0] is never written and always reads 0.
- Reset:
  - rst = 1 asynchronously clears all reg_count entries to 0, regardless of clk.
  - While rst = 1: Read_data_1 = Read_data_2 = 0, WB_Write_Valid = 0.
  - WB_Write_Data still follows its inputs (M/WB itself resets to 0, so it is 0 in practice).
- Reset mid-operation: a write coincident with rst assertion is lost. After deassertion, the first write occurs at the first posedge with rst = 0.
- Read ports (combinational, zero latency), per port n:
  - Read_addr_n == 0 -> 0.
  - Else if WB_Write_Valid and WB_WR_out == Read_addr_n -> WB_Write_Data (write-through bypass).
  - Else -> regs[Read_addr_n].
  - Bypass guarantees same-cycle read-after-write regardless of the negedge/posedge phase relationship.
- Both ports may read the same index simultaneously; both receive identical values, including under bypass.
- X on WB_WR_out while WB_RegWrite = 0 must not corrupt any register. Assertion: no write when WB_RegWrite = 0.
- Back-to-back writes to the same index: the last committed value wins. No write merging or queuing.
- Latency: write visible via bypass in the same cycle and from the array after the committing posedge.

Decomposition:
- Shared cpu_pkg holds:
  - data_size and addr_size constants
  - REG_ZERO = 5'd0
  - REG_RA = 5'd31, for link-write checks in the bench
- One natural sub-module: regfile_core, holding the 32xdata_size array, async reset, posedge write port and two raw read ports.
- wb_regfile contains the MemtoReg mux, the WB_Write_Valid qualifier, the zero-register masking and the bypass muxes.

Test Plan:
- Reset: preload regs[1..31] with nonzero values; assert rst mid-cycle (between edges) -> all reads return 0 immediately and WB_Write_Valid = 0; after release, reading any index returns 0.
- Writeback select:
  - RegWrite = 1, WR = 8, MemtoReg = 0, WD_out = 0x1234_5678, DM = 0xDEAD_BEEF -> after posedge, Read_addr_1 = 8 gives 0x1234_5678.
  - Repeat with MemtoReg = 1 -> 0xDEAD_BEEF.
- Zero register: RegWrite = 1, WR = 0, WD_out = 0xFFFF_FFFF -> WB_Write_Valid = 0; Read_data of index 0 stays 0; no bypass on index 0.
- Bypass: regs[5] = 0x11; WB drives WR = 5, WD_out = 0x22, RegWrite = 1 -> before the posedge, Read_data_1 and Read_data_2 (both addr 5) = 0x22. After the edge with RegWrite = 0, both still read 0x22 from the array.
- Disabled write: RegWrite = 0, WR = 9, WD_out = 0x55 for several edges -> regs[9] unchanged (0) and no bypass on port reads.
- Back-to-back: writes of 0xA, 0xB and 0xC to index 31 on consecutive cycles -> reads return 0xA, 0xB, 0xC on each respective cycle; final array value is 0xC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants for the writeback/register-file slice.
package cpu_pkg;

    localparam int DATA_SIZE = 32;
    localparam int ADDR_SIZE = 5;
    localparam int REG_COUNT = 2 ** ADDR_SIZE;

    localparam logic [ADDR_SIZE-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_SIZE-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_core.sv
// 32-entry register array: async clear, one posedge write port,
// two raw combinational read ports.
module regfile_core
    import cpu_pkg::*;
#(
    parameter int data_size = DATA_SIZE,
    parameter int addr_size = ADDR_SIZE,
    parameter int reg_count = REG_COUNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [addr_size-1:0] waddr,
    input  logic [data_size-1:0] wdata,
    input  logic [addr_size-1:0] raddr_1,
    input  logic [addr_size-1:0] raddr_2,
    output logic [data_size-1:0] rdata_1,
    output logic [data_size-1:0] rdata_2
);

    logic [data_size-1:0] regs [reg_count];

    // Entry 0 is never written so it stays at its reset value of 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < reg_count; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_1 = regs[raddr_1];
    assign rdata_2 = regs[raddr_2];

endmodule

// File: rtl/wb_regfile.sv
// Writeback select, register file commit and bypassed ID read ports;
// also exports the writeback value for EX-stage forwarding.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int data_size = DATA_SIZE,
    parameter int addr_size = ADDR_SIZE,
    parameter int reg_count = REG_COUNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 WB_MemtoReg,
    input  logic                 WB_RegWrite,
    input  logic [data_size-1:0] WB_DM_Read_Data,
    input  logic [data_size-1:0] WB_WD_out,
    input  logic [addr_size-1:0] WB_WR_out,
    input  logic [addr_size-1:0] Read_addr_1,
    input  logic [addr_size-1:0] Read_addr_2,
    output logic [data_size-1:0] Read_data_1,
    output logic [data_size-1:0] Read_data_2,
    output logic [data_size-1:0] WB_Write_Data,
    output logic                 WB_Write_Valid
);

    logic [data_size-1:0] raw_1;
    logic [data_size-1:0] raw_2;

    assign WB_Write_Data = WB_MemtoReg ? WB_DM_Read_Data : WB_WD_out;

    // && short-circuits an X index to 0 when RegWrite is low.
    assign WB_Write_Valid = !rst && WB_RegWrite
                         && (WB_WR_out != REG_ZERO);

    regfile_core #(
        .data_size (data_size),
        .addr_size (addr_size),
        .reg_count (reg_count)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .we      (WB_Write_Valid),
        .waddr   (WB_WR_out),
        .wdata   (WB_Write_Data),
        .raddr_1 (Read_addr_1),
        .raddr_2 (Read_addr_2),
        .rdata_1 (raw_1),
        .rdata_2 (raw_2)
    );

    always_comb begin
        Read_data_1 = raw_1;
        if (rst || Read_addr_1 == REG_ZERO) begin
            Read_data_1 = '0;
        end else if (WB_Write_Valid && WB_WR_out == Read_addr_1) begin
            Read_data_1 = WB_Write_Data;
        end
    end

    always_comb begin
        Read_data_2 = raw_2;
        if (rst || Read_addr_2 == REG_ZERO) begin
            Read_data_2 = '0;
        end else if (WB_Write_Valid && WB_WR_out == Read_addr_2) begin
            Read_data_2 = WB_Write_Data;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (WB_RegWrite || !WB_Write_Valid)
            else $error("write commit without WB_RegWrite");
        end
    end

endmodule
